id_exe_reg: RTL and testbench

Pipeline register between the instruction-decode stage and the execute stage of the five-stage ARM core. It captures the decoder's control outputs (B, S, EXE_CMD, WB_EN, MEM_R_EN, MEM_W_EN) together with the decoded operands.
- On a hazard or a failed condition check, it kills the instruction's side effects by inserting a bubble.
- On a branch flush, it clears the whole slot.
- On a memory freeze, it holds its contents.
- It keeps saturating bubble and flush counters for performance debug.

---
 rtl/id_exe_reg.sv | 139 +++++++++++++
 tb/tb_id_exe_reg.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_reg.sv
// rtl/id_exe_reg.sv - ID/EXE pipeline register with bubble, flush, freeze and event counters
module id_exe_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_en_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             b_in,
  input  logic             s_in,
  input  logic [3:0]       exe_cmd_in,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      val_rn_in,
  input  logic [31:0]      val_rm_in,
  input  logic             imm_in,
  input  logic [11:0]      shift_operand_in,
  input  logic [23:0]      signed_imm_24_in,
  input  logic [3:0]       dest_in,
  input  logic [3:0]       src1_in,
  input  logic [3:0]       src2_in,
  input  logic             carry_in,
  input  logic             cond_ok,
  input  logic             hazard,
  input  logic             freeze,
  input  logic             flush,
  output logic             wb_en_out,
  output logic             mem_r_en_out,
  output logic             mem_w_en_out,
  output logic             b_out,
  output logic             s_out,
  output logic [3:0]       exe_cmd_out,
  output logic [31:0]      pc_out,
  output logic [31:0]      val_rn_out,
  output logic [31:0]      val_rm_out,
  output logic             imm_out,
  output logic [11:0]      shift_operand_out,
  output logic [23:0]      signed_imm_24_out,
  output logic [3:0]       dest_out,
  output logic [3:0]       src1_out,
  output logic [3:0]       src2_out,
  output logic             carry_out,
  output logic             valid_out,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A bubble kills side effects but keeps operands visible to forwarding.
  logic bubble;
  assign bubble = hazard | ~cond_ok;

  // Control group: zeroed on flush or bubble, held on freeze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      b_out        <= 1'b0;
      s_out        <= 1'b0;
      exe_cmd_out  <= 4'd0;
      valid_out    <= 1'b0;
    end else if (!freeze) begin
      if (flush || bubble) begin
        wb_en_out    <= 1'b0;
        mem_r_en_out <= 1'b0;
        mem_w_en_out <= 1'b0;
        b_out        <= 1'b0;
        s_out        <= 1'b0;
        exe_cmd_out  <= 4'd0;
        valid_out    <= 1'b0;
      end else begin
        wb_en_out    <= wb_en_in;
        mem_r_en_out <= mem_r_en_in;
        mem_w_en_out <= mem_w_en_in;
        b_out        <= b_in;
        s_out        <= s_in;
        exe_cmd_out  <= exe_cmd_in;
        valid_out    <= 1'b1;
      end
    end
  end

  // Data group: cleared only by flush, loads through bubbles, held on freeze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_out            <= 32'd0;
      val_rn_out        <= 32'd0;
      val_rm_out        <= 32'd0;
      imm_out           <= 1'b0;
      shift_operand_out <= 12'd0;
      signed_imm_24_out <= 24'd0;
      dest_out          <= 4'd0;
      src1_out          <= 4'd0;
      src2_out          <= 4'd0;
      carry_out         <= 1'b0;
    end else if (!freeze) begin
      if (flush) begin
        pc_out            <= 32'd0;
        val_rn_out        <= 32'd0;
        val_rm_out        <= 32'd0;
        imm_out           <= 1'b0;
        shift_operand_out <= 12'd0;
        signed_imm_24_out <= 24'd0;
        dest_out          <= 4'd0;
        src1_out          <= 4'd0;
        src2_out          <= 4'd0;
        carry_out         <= 1'b0;
      end else begin
        pc_out            <= pc_in;
        val_rn_out        <= val_rn_in;
        val_rm_out        <= val_rm_in;
        imm_out           <= imm_in;
        shift_operand_out <= shift_operand_in;
        signed_imm_24_out <= signed_imm_24_in;
        dest_out          <= dest_in;
        src1_out          <= src1_in;
        src2_out          <= src2_in;
        carry_out         <= carry_in;
      end
    end
  end

  // Saturating event counters; flush outranks bubble so a cycle counts once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (!freeze) begin
      if (flush) begin
        if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
      end else if (bubble) begin
        if (bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_exe_reg.sv
// tb/tb_id_exe_reg.sv - scoreboard bench for id_exe_reg with a 4-bit counter instance for saturation
module tb_id_exe_reg;

  typedef struct packed {
    logic        wb, mr, mw, b, s;
    logic [3:0]  cmd;
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] si;
    logic [3:0]  d, s1, s2;
    logic        c;
    logic        v;
    logic [15:0] bc, fc;
  } st_t;

  typedef struct packed {
    logic [3:0] bc, fc;
  } sat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in;
  logic [3:0]  exe_cmd_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic        imm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  dest_in, src1_in, src2_in;
  logic        carry_in, cond_ok, hazard, freeze, flush;

  logic wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out;
  logic [3:0]  exe_cmd_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic        imm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;
  logic [3:0]  dest_out, src1_out, src2_out;
  logic        carry_out, valid_out;
  logic [15:0] bubble_cnt, flush_cnt;

  logic wb4, mr4, mw4, b4, s4, imm4, c4, v4;
  logic [3:0]  cmd4, d4, s14, s24, bc4, fc4;
  logic [31:0] pc4, rn4, rm4;
  logic [11:0] sh4;
  logic [23:0] si4;

  int tests = 0;
  int fails = 0;

  st_t  model;
  sat_t model4;
  st_t  exp_q[$];
  sat_t exp4_q[$];
  st_t  obs;
  sat_t obs4;

  always #5 clk = ~clk;

  assign obs = {wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, exe_cmd_out,
                pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
                signed_imm_24_out, dest_out, src1_out, src2_out, carry_out,
                valid_out, bubble_cnt, flush_cnt};
  assign obs4 = {bc4, fc4};

  id_exe_reg #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in), .pc_in(pc_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .carry_in(carry_in),
    .cond_ok(cond_ok), .hazard(hazard), .freeze(freeze), .flush(flush),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .b_out(b_out), .s_out(s_out), .exe_cmd_out(exe_cmd_out), .pc_out(pc_out),
    .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .imm_out(imm_out),
    .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out),
    .carry_out(carry_out), .valid_out(valid_out),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  id_exe_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in), .pc_in(pc_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .carry_in(carry_in),
    .cond_ok(cond_ok), .hazard(hazard), .freeze(freeze), .flush(flush),
    .wb_en_out(wb4), .mem_r_en_out(mr4), .mem_w_en_out(mw4),
    .b_out(b4), .s_out(s4), .exe_cmd_out(cmd4), .pc_out(pc4),
    .val_rn_out(rn4), .val_rm_out(rm4), .imm_out(imm4),
    .shift_operand_out(sh4), .signed_imm_24_out(si4),
    .dest_out(d4), .src1_out(s14), .src2_out(s24),
    .carry_out(c4), .valid_out(v4),
    .bubble_cnt(bc4), .flush_cnt(fc4)
  );

  // Behavioural next-state of the register slot from the current inputs.
  function automatic st_t model_next(input st_t cur);
    st_t n;
    n = cur;
    if (freeze) return cur;
    if (flush) begin
      n = '0;
      n.bc = cur.bc;
      n.fc = (cur.fc == 16'hFFFF) ? cur.fc : cur.fc + 16'd1;
    end else begin
      n.pc = pc_in; n.rn = val_rn_in; n.rm = val_rm_in; n.imm = imm_in;
      n.sh = shift_operand_in; n.si = signed_imm_24_in;
      n.d = dest_in; n.s1 = src1_in; n.s2 = src2_in; n.c = carry_in;
      if (hazard || !cond_ok) begin
        {n.wb, n.mr, n.mw, n.b, n.s, n.cmd, n.v} = '0;
        n.bc = (cur.bc == 16'hFFFF) ? cur.bc : cur.bc + 16'd1;
      end else begin
        n.wb = wb_en_in; n.mr = mem_r_en_in; n.mw = mem_w_en_in;
        n.b = b_in; n.s = s_in; n.cmd = exe_cmd_in; n.v = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic sat_t model4_next(input sat_t cur);
    sat_t n;
    n = cur;
    if (!freeze) begin
      if (flush) n.fc = (cur.fc == 4'hF) ? cur.fc : cur.fc + 4'd1;
      else if (hazard || !cond_ok) n.bc = (cur.bc == 4'hF) ? cur.bc : cur.bc + 4'd1;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [255:0] o, input logic [255:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Drive current inputs for one edge, then pop and compare what the slot captured.
  task automatic step(input string tag);
    st_t  e;
    sat_t e4;
    exp_q.push_back(model_next(model));
    exp4_q.push_back(model4_next(model4));
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    e4 = exp4_q.pop_front();
    check(tag, 256'(obs), 256'(e));
    check({tag, "_cnt4"}, 256'(obs4), 256'(e4));
    model  = e;
    model4 = e4;
  endtask

  task automatic set_all(input logic val);
    {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, carry_in} = {7{val}};
    exe_cmd_in = {4{val}}; pc_in = {32{val}}; val_rn_in = {32{val}}; val_rm_in = {32{val}};
    shift_operand_in = {12{val}}; signed_imm_24_in = {24{val}};
    dest_in = {4{val}}; src1_in = {4{val}}; src2_in = {4{val}};
    {cond_ok, hazard, freeze, flush} = {4{val}};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model = '0;
    model4 = '0;
    set_all(1'b1);
    hazard = 1'b0; freeze = 1'b0; flush = 1'b0;
    #12;
    check("reset_state", 256'(obs), 256'(0));
    check("reset_state4", 256'(obs4), 256'(0));
    rst = 1'b1;
    step("load_ones");

    // Asynchronous reset between edges with every input high, including freeze.
    set_all(1'b1);
    #2 rst = 1'b0;
    #1;
    check("async_reset", 256'(obs), 256'(0));
    check("async_reset_valid", 256'(valid_out), 256'(0));
    model = '0; model4 = '0;
    @(negedge clk);
    rst = 1'b1;
    set_all(1'b0);

    // Normal capture.
    exe_cmd_in = 4'b0010; wb_en_in = 1'b1; s_in = 1'b1; pc_in = 32'h0000_0010;
    val_rn_in = 32'h5; dest_in = 4'd3; cond_ok = 1'b1;
    step("normal");
    check("normal_cmd", 256'(exe_cmd_out), 256'(4'b0010));
    check("normal_pc", 256'(pc_out), 256'(32'h10));
    check("normal_valid", 256'(valid_out), 256'(1));

    // Hazard bubble for two cycles.
    mem_r_en_in = 1'b1; src1_in = 4'd7; hazard = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step("hazard");
      check("hazard_src1", 256'(src1_out), 256'(7));
      check("hazard_mr", 256'({mem_r_en_out, exe_cmd_out, valid_out}), 256'(0));
    end
    check("hazard_bcnt", 256'(bubble_cnt), 256'(2));

    // Same with a failed condition check.
    hazard = 1'b0; cond_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step("cond_fail");
      check("cond_src1", 256'(src1_out), 256'(7));
      check("cond_mr", 256'({mem_r_en_out, exe_cmd_out, valid_out}), 256'(0));
    end
    check("cond_bcnt", 256'(bubble_cnt), 256'(4));

    // Live instruction, then flush held off by freeze.
    cond_ok = 1'b1; mem_r_en_in = 1'b0; mem_w_en_in = 1'b1; pc_in = 32'hDEAD_0004;
    val_rm_in = 32'h1234_5678; exe_cmd_in = 4'b0100; src2_in = 4'd9;
    step("live");
    flush = 1'b1; freeze = 1'b1; pc_in = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) step("flush_frozen");
    check("frozen_pc", 256'(pc_out), 256'(32'hDEAD_0004));
    check("frozen_fcnt", 256'(flush_cnt), 256'(0));
    freeze = 1'b0;
    step("flush_release");
    check("flush_zero", 256'({pc_out, val_rm_out, src2_out, mem_w_en_out, valid_out}), 256'(0));
    check("flush_fcnt", 256'(flush_cnt), 256'(1));

    // Flush and hazard together: flush wins, counted once.
    flush = 1'b0;
    step("live2");
    flush = 1'b1; hazard = 1'b1;
    step("flush_hazard");
    check("fh_fcnt", 256'(flush_cnt), 256'(2));
    check("fh_bcnt", 256'(bubble_cnt), 256'(4));
    check("fh_pc", 256'(pc_out), 256'(0));

    // Freeze alone with changing inputs holds the slot.
    flush = 1'b0; hazard = 1'b0;
    step("live3");
    freeze = 1'b1;
    pc_in = 32'h7777_7777; dest_in = 4'hC;
    step("freeze_a");
    pc_in = 32'h8888_8888;
    step("freeze_b");
    freeze = 1'b0;

    // Saturation of the 4-bit instance.
    hazard = 1'b1;
    for (int i = 0; i < 20; i++) step("sat");
    check("sat_bcnt4", 256'(bc4), 256'(15));
    check("sat_bcnt16", 256'(bubble_cnt), 256'(24));
    hazard = 1'b0;

    // Randomised mix of events and payloads.
    for (int i = 0; i < 40; i++) begin
      {wb_en_in, mem_r_en_in, b_in, s_in, imm_in, carry_in} = 6'($urandom);
      mem_w_en_in = ~mem_r_en_in & 1'($urandom);
      exe_cmd_in = 4'($urandom); pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
      shift_operand_in = 12'($urandom); signed_imm_24_in = 24'($urandom);
      dest_in = 4'($urandom); src1_in = 4'($urandom); src2_in = 4'($urandom);
      cond_ok = ($urandom_range(0, 3) != 0);
      hazard  = ($urandom_range(0, 4) == 0);
      freeze  = ($urandom_range(0, 4) == 0);
      flush   = ($urandom_range(0, 5) == 0);
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
